// File: rtl/reg_seq_8088_pkg.sv
// Shared types for the 8088 register-port sequencer: request opcodes,
// sequencer states and the bank write-data formatting helper.
package reg_seq_8088_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_XCHG  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    XR   = 3'd3,
    XA   = 3'd4,
    XB   = 3'd5,
    RSP  = 3'd6
  } state_e;

  // Byte writes carry their payload in the low byte; the bank routes it
  // to the high or low half using bank_select_high_low.
  function automatic logic [15:0] fmt_write(input logic w, input logic [15:0] d);
    return w ? d : {8'h00, d[7:0]};
  endfunction

endpackage

// File: rtl/reg_field_map_8088.sv
// Translates an 8088 W bit plus 3-bit register field into a bank index,
// size and high/low select, and extracts the addressed byte or word
// from the full 16-bit register read back from the bank.
module reg_field_map_8088
  import reg_seq_8088_pkg::*;
(
  input  logic        w,
  input  logic [2:0]  field,
  input  logic [15:0] rd_data,
  output logic [2:0]  idx,
  output logic        size,
  output logic        sel_high,
  output logic [15:0] ext_data
);

  // Byte fields 4-7 (AH/CH/DH/BH) alias the high halves of registers 0-3.
  assign idx      = w ? field : {1'b0, field[1:0]};
  assign size     = w;
  assign sel_high = ~w & field[2];
  assign ext_data = w ? rd_data
                      : {8'h00, (field[2] ? rd_data[15:8] : rd_data[7:0])};

endmodule

// File: rtl/reg_port_seq_8088.sv
// Register-port sequencer for register_bank_8088. Accepts READ / WRITE /
// XCHG requests, drives the bank ports and returns read results.
// XCHG support is compiled in only when REG_SEQ_XCHG_EN is defined;
// otherwise op 10 is treated as a reserved op and flagged on err.
module reg_port_seq_8088
  import reg_seq_8088_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_w,
  input  logic [2:0]  req_reg_a,
  input  logic [2:0]  req_reg_b,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data_a,
  output logic [15:0] rsp_data_b,
  output logic        err,
  output logic        bank_en_write,
  output logic [2:0]  bank_reg_write,
  output logic [15:0] bank_write_data,
  output logic [2:0]  bank_reg_read1,
  output logic [2:0]  bank_reg_read2,
  output logic        bank_size,
  output logic        bank_select_high_low,
  input  logic [15:0] bank_read_data1,
  input  logic [15:0] bank_read_data2
);

  state_e      state;
  logic        lat_w;
  logic [2:0]  lat_a;
  logic [2:0]  lat_b;
  logic [15:0] lat_data;

  logic [2:0]  idx_a, idx_b;
  logic        size_a, size_b;
  logic        sel_a, sel_b;
  logic [15:0] ext_a, ext_b;

`ifdef REG_SEQ_XCHG_EN
  logic [15:0] tmp_a;
  logic [15:0] tmp_b;
`endif

  reg_field_map_8088 u_map_a (
    .w        (lat_w),
    .field    (lat_a),
    .rd_data  (bank_read_data1),
    .idx      (idx_a),
    .size     (size_a),
    .sel_high (sel_a),
    .ext_data (ext_a)
  );

  reg_field_map_8088 u_map_b (
    .w        (lat_w),
    .field    (lat_b),
    .rd_data  (bank_read_data2),
    .idx      (idx_b),
    .size     (size_b),
    .sel_high (sel_b),
    .ext_data (ext_b)
  );

  // Ready only in IDLE, and held low for as long as reset is asserted.
  assign req_ready = reset & (state == IDLE);

  // Bank port drive decoded from state so the bank sees the write in the
  // very cycle the state is entered; idle ports are held at zero.
  always_comb begin
    bank_en_write        = 1'b0;
    bank_reg_write       = 3'd0;
    bank_write_data      = 16'h0000;
    bank_reg_read1       = 3'd0;
    bank_reg_read2       = 3'd0;
    bank_size            = 1'b0;
    bank_select_high_low = 1'b0;
    case (state)
      RD: begin
        bank_reg_read1 = idx_a;
        bank_reg_read2 = idx_b;
      end
      WR: begin
        bank_en_write        = 1'b1;
        bank_reg_write       = idx_a;
        bank_write_data      = fmt_write(lat_w, lat_data);
        bank_size            = size_a;
        bank_select_high_low = sel_a;
      end
`ifdef REG_SEQ_XCHG_EN
      XR: begin
        bank_reg_read1 = idx_a;
        bank_reg_read2 = idx_b;
      end
      XA: begin
        bank_en_write        = 1'b1;
        bank_reg_write       = idx_a;
        bank_write_data      = fmt_write(lat_w, tmp_b);
        bank_size            = size_a;
        bank_select_high_low = sel_a;
      end
      XB: begin
        bank_en_write        = 1'b1;
        bank_reg_write       = idx_b;
        bank_write_data      = fmt_write(lat_w, tmp_a);
        bank_size            = size_b;
        bank_select_high_low = sel_b;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer FSM: request latch, state advance, response and err registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_w      <= 1'b0;
      lat_a      <= 3'd0;
      lat_b      <= 3'd0;
      lat_data   <= 16'h0000;
      rsp_valid  <= 1'b0;
      rsp_data_a <= 16'h0000;
      rsp_data_b <= 16'h0000;
      err        <= 1'b0;
`ifdef REG_SEQ_XCHG_EN
      tmp_a      <= 16'h0000;
      tmp_b      <= 16'h0000;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_w    <= req_w;
            lat_a    <= req_reg_a;
            lat_b    <= req_reg_b;
            lat_data <= req_data;
            case (op_e'(req_op))
              OP_READ:  state <= RD;
              OP_WRITE: state <= WR;
`ifdef REG_SEQ_XCHG_EN
              OP_XCHG:  state <= XR;
`endif
              default:  err   <= 1'b1;
            endcase
          end
        end
        RD: begin
          rsp_data_a <= ext_a;
          rsp_data_b <= ext_b;
          rsp_valid  <= 1'b1;
          state      <= RSP;
        end
        WR: state <= IDLE;
`ifdef REG_SEQ_XCHG_EN
        XR: begin
          tmp_a <= ext_a;
          tmp_b <= ext_b;
          state <= XA;
        end
        XA: state <= XB;
        XB: begin
          rsp_data_a <= tmp_a;
          rsp_data_b <= tmp_b;
          rsp_valid  <= 1'b1;
          state      <= RSP;
        end
`endif
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_port_seq_8088.sv
// Self-checking bench for reg_port_seq_8088 with a behavioural register
// bank and a word/byte reference model of the 8088 register file.
module tb_reg_port_seq_8088;

`ifdef REG_SEQ_XCHG_EN
  localparam bit XEN = 1'b1;
`else
  localparam bit XEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_w;
  logic [2:0]  req_reg_a;
  logic [2:0]  req_reg_b;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data_a;
  logic [15:0] rsp_data_b;
  logic        err;
  logic        bank_en_write;
  logic [2:0]  bank_reg_write;
  logic [15:0] bank_write_data;
  logic [2:0]  bank_reg_read1;
  logic [2:0]  bank_reg_read2;
  logic        bank_size;
  logic        bank_select_high_low;
  logic [15:0] bank_read_data1;
  logic [15:0] bank_read_data2;

  logic        bank_clear;
  logic [15:0] bank_regs [8];
  logic [15:0] exp_regs [8];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [15:0] data;
    int          rsp_cyc;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [7:0]  exp_wr;
    logic [7:0]  exp_err;
    bit          chk_w;
    logic [2:0]  widx;
    logic        wsize;
    logic        wsel;
    logic [15:0] wdata;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  reg_port_seq_8088 dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_op               (req_op),
    .req_w                (req_w),
    .req_reg_a            (req_reg_a),
    .req_reg_b            (req_reg_b),
    .req_data             (req_data),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_data_a           (rsp_data_a),
    .rsp_data_b           (rsp_data_b),
    .err                  (err),
    .bank_en_write        (bank_en_write),
    .bank_reg_write       (bank_reg_write),
    .bank_write_data      (bank_write_data),
    .bank_reg_read1       (bank_reg_read1),
    .bank_reg_read2       (bank_reg_read2),
    .bank_size            (bank_size),
    .bank_select_high_low (bank_select_high_low),
    .bank_read_data1      (bank_read_data1),
    .bank_read_data2      (bank_read_data2)
  );

  // Behavioural register_bank_8088: combinational reads, byte-preserving writes.
  assign bank_read_data1 = bank_regs[bank_reg_read1];
  assign bank_read_data2 = bank_regs[bank_reg_read2];

  always @(posedge clk) begin
    if (bank_clear) begin
      for (int i = 0; i < 8; i++) bank_regs[i] <= 16'h0000;
    end else if (bank_en_write) begin
      if (bank_size) bank_regs[bank_reg_write] <= bank_write_data;
      else if (bank_select_high_low) bank_regs[bank_reg_write][15:8] <= bank_write_data[7:0];
      else bank_regs[bank_reg_write][7:0] <= bank_write_data[7:0];
    end
  end

  function automatic vec_t mk(input logic [1:0] op, input logic w, input logic [2:0] a,
                              input logic [2:0] b, input logic [15:0] data, input int rsp_cyc,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic [7:0] wr, input logic [7:0] errm, input bit chk_w,
                              input logic [2:0] widx, input logic wsize, input logic wsel,
                              input logic [15:0] wdata);
    vec_t v;
    v.op = op; v.w = w; v.a = a; v.b = b; v.data = data;
    v.rsp_cyc = rsp_cyc; v.exp_a = ea; v.exp_b = eb;
    v.exp_wr = wr; v.exp_err = errm; v.chk_w = chk_w;
    v.widx = widx; v.wsize = wsize; v.wsel = wsel; v.wdata = wdata;
    return v;
  endfunction

  // Reference model: AL..BL are low bytes of regs 0-3, AH..BH the high bytes.
  function automatic logic [15:0] m_read(input logic w, input logic [2:0] f);
    logic [15:0] word;
    if (w) return exp_regs[f];
    word = exp_regs[f % 4];
    return (f >= 3'd4) ? (word >> 8) : (word & 16'h00FF);
  endfunction

  task automatic m_write(input logic w, input logic [2:0] f, input logic [15:0] d);
    if (w) exp_regs[f] = d;
    else if (f >= 3'd4) exp_regs[f % 4] = (exp_regs[f % 4] & 16'h00FF) | ((d & 16'h00FF) << 8);
    else exp_regs[f % 4] = (exp_regs[f % 4] & 16'hFF00) | (d & 16'h00FF);
  endtask

  task automatic apply_model(input vec_t v);
    logic [15:0] va, vb;
    if (v.op == 2'b01) m_write(v.w, v.a, v.data);
    else if (v.op == 2'b10 && XEN) begin
      va = m_read(v.w, v.a);
      vb = m_read(v.w, v.b);
      m_write(v.w, v.a, vb);
      m_write(v.w, v.b, va);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bank(input string name);
    int bad = 0;
    for (int i = 0; i < 8; i++) if (bank_regs[i] !== exp_regs[i]) bad++;
    check_output(name, bad, 0);
  endtask

  // Drive one request at a negedge, let it be accepted at E0, then watch
  // six samples (each midway after E1..E6) for writes, err and response.
  task automatic apply_stimulus(input vec_t v, input string tag);
    logic [7:0]  wr_mask = 8'h00;
    logic [7:0]  err_mask = 8'h00;
    int          rsp_cyc = 0;
    logic [15:0] ra = 16'h0, rb = 16'h0;
    logic [2:0]  widx = 3'd0;
    logic        wsize = 1'b0, wsel = 1'b0;
    logic [15:0] wdata = 16'h0;
    logic        rdy2 = 1'b0;
    bit          exp_rdy2;
    req_valid = 1'b1; req_op = v.op; req_w = v.w;
    req_reg_a = v.a; req_reg_b = v.b; req_data = v.data;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 2'b00; req_data = 16'h0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bank_en_write) begin
        if (wr_mask == 8'h00) begin
          widx = bank_reg_write; wsize = bank_size;
          wsel = bank_select_high_low; wdata = bank_write_data;
        end
        wr_mask[i] = 1'b1;
      end
      if (err) err_mask[i] = 1'b1;
      if (rsp_valid && rsp_cyc == 0) begin
        rsp_cyc = i; ra = rsp_data_a; rb = rsp_data_b;
      end
      if (i == 2) rdy2 = req_ready;
    end
    exp_rdy2 = (v.rsp_cyc == 0) && (v.exp_wr != 8'b1100);
    check_output({tag, ".wr_mask"}, wr_mask, v.exp_wr);
    check_output({tag, ".err_mask"}, err_mask, v.exp_err);
    check_output({tag, ".rsp_cyc"}, rsp_cyc, v.rsp_cyc);
    check_output({tag, ".ready_e1"}, rdy2, exp_rdy2);
    if (v.rsp_cyc != 0) begin
      check_output({tag, ".rsp_a"}, ra, v.exp_a);
      check_output({tag, ".rsp_b"}, rb, v.exp_b);
    end
    if (v.chk_w && v.exp_wr != 8'h00) begin
      check_output({tag, ".widx"}, widx, v.widx);
      check_output({tag, ".wsize"}, wsize, v.wsize);
      check_output({tag, ".wsel"}, wsel, v.wsel);
      check_output({tag, ".wdata"}, wdata, v.wdata);
    end
    apply_model(v);
    check_bank({tag, ".bank"});
  endtask

  initial begin
    vec_t        v;
    logic [15:0] ha, hb, va, vb;
    reset = 1'b0; bank_clear = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_w = 1'b0;
    req_reg_a = 3'd0; req_reg_b = 3'd0; req_data = 16'h0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0000;

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("rst.req_ready", req_ready, 1'b0);
    check_output("rst.bank", {bank_en_write, bank_reg_write, bank_write_data, bank_reg_read1,
                              bank_reg_read2, bank_size, bank_select_high_low}, 32'h0);
    check_output("rst.rsp_valid", rsp_valid, 1'b0);
    check_output("rst.rsp_data", {rsp_data_a, rsp_data_b}, 32'h0);
    check_output("rst.err", err, 1'b0);
    #2 reset = 1'b1;
    #1 check_output("rst.release_ready", req_ready, 1'b1);
    bank_clear = 1'b0;
    @(negedge clk);

    // Directed vectors from the register-mapping rules.
    vecs.push_back(mk(2'b01,1,3,0,16'hBEEF, 0,0,0, 8'b10,0, 1, 3,1,0,16'hBEEF));
    vecs.push_back(mk(2'b00,1,3,0,16'h0,    2,16'hBEEF,16'h0000, 0,0, 0, 0,0,0,0));
    vecs.push_back(mk(2'b01,0,4,0,16'h1234, 0,0,0, 8'b10,0, 1, 0,0,1,16'h0034));
    vecs.push_back(mk(2'b00,1,0,4,16'h0,    2,16'h3400,16'h0000, 0,0, 0, 0,0,0,0));
    vecs.push_back(mk(2'b00,0,4,3,16'h0,    2,16'h0034,16'h00EF, 0,0, 0, 0,0,0,0));
    vecs.push_back(mk(2'b01,1,1,0,16'h1111, 0,0,0, 8'b10,0, 1, 1,1,0,16'h1111));
    vecs.push_back(mk(2'b01,1,2,0,16'h2222, 0,0,0, 8'b10,0, 1, 2,1,0,16'h2222));
`ifdef REG_SEQ_XCHG_EN
    vecs.push_back(mk(2'b10,1,1,2,16'h0,    4,16'h1111,16'h2222, 8'b1100,0, 1, 1,1,0,16'h2222));
    vecs.push_back(mk(2'b00,1,1,2,16'h0,    2,16'h2222,16'h1111, 0,0, 0, 0,0,0,0));
    vecs.push_back(mk(2'b01,1,0,0,16'hAB12, 0,0,0, 8'b10,0, 1, 0,1,0,16'hAB12));
    vecs.push_back(mk(2'b10,0,0,4,16'h0,    4,16'h0012,16'h00AB, 8'b1100,0, 1, 0,0,0,16'h00AB));
    vecs.push_back(mk(2'b00,1,0,0,16'h0,    2,16'h12AB,16'h12AB, 0,0, 0, 0,0,0,0));
    vecs.push_back(mk(2'b10,1,3,3,16'h0,    4,16'hBEEF,16'hBEEF, 8'b1100,0, 1, 3,1,0,16'hBEEF));
    vecs.push_back(mk(2'b00,0,7,2,16'h0,    2,16'h00BE,16'h0011, 0,0, 0, 0,0,0,0));
`else
    vecs.push_back(mk(2'b10,1,1,2,16'h0,    0,0,0, 0,8'b10, 0, 0,0,0,0));
    vecs.push_back(mk(2'b00,1,1,2,16'h0,    2,16'h1111,16'h2222, 0,0, 0, 0,0,0,0));
    vecs.push_back(mk(2'b01,1,0,0,16'hAB12, 0,0,0, 8'b10,0, 1, 0,1,0,16'hAB12));
    vecs.push_back(mk(2'b10,0,0,4,16'h0,    0,0,0, 0,8'b10, 0, 0,0,0,0));
    vecs.push_back(mk(2'b00,1,0,0,16'h0,    2,16'hAB12,16'hAB12, 0,0, 0, 0,0,0,0));
    vecs.push_back(mk(2'b00,0,7,2,16'h0,    2,16'h00BE,16'h0022, 0,0, 0, 0,0,0,0));
`endif
    vecs.push_back(mk(2'b11,1,5,6,16'h5A5A, 0,0,0, 0,8'b10, 0, 0,0,0,0));
    foreach (vecs[i]) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Response held off for three cycles: data stable, no new request taken.
    rsp_ready = 1'b0;
    ha = m_read(1'b1, 3'd3); hb = m_read(1'b1, 3'd1);
    req_valid = 1'b1; req_op = 2'b00; req_w = 1'b1; req_reg_a = 3'd3; req_reg_b = 3'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("hold.rsp_valid", rsp_valid, 1'b1);
      check_output("hold.rsp_data", {rsp_data_a, rsp_data_b}, {ha, hb});
      check_output("hold.req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_output("hold.release_valid", rsp_valid, 1'b0);
    check_output("hold.release_ready", req_ready, 1'b1);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      v = mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 16'hFFFF), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      case (v.op)
        2'b00: begin v.rsp_cyc = 2; v.exp_a = m_read(v.w, v.a); v.exp_b = m_read(v.w, v.b); end
        2'b01: v.exp_wr = 8'b10;
        2'b10: begin
          if (XEN) begin
            v.rsp_cyc = 4; v.exp_wr = 8'b1100;
            v.exp_a = m_read(v.w, v.a); v.exp_b = m_read(v.w, v.b);
          end else v.exp_err = 8'b10;
        end
        default: v.exp_err = 8'b10;
      endcase
      apply_stimulus(v, $sformatf("rnd%0d", n));
    end

    // Reset in the middle of a READ: abort with no response, bank untouched.
    req_valid = 1'b1; req_op = 2'b00; req_w = 1'b1; req_reg_a = 3'd2; req_reg_b = 3'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("abort_rd.rsp_valid", rsp_valid, 1'b0);
    check_output("abort_rd.req_ready", req_ready, 1'b0);
    check_output("abort_rd.read_idx", {bank_reg_read1, bank_reg_read2}, 6'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check_output("abort_rd.ready_after", req_ready, 1'b1);
    @(negedge clk);
    check_bank("abort_rd.bank");

`ifdef REG_SEQ_XCHG_EN
    // Reset between the two XCHG writes: only the first write survives.
    va = m_read(1'b1, 3'd5); vb = m_read(1'b1, 3'd6);
    req_valid = 1'b1; req_op = 2'b10; req_w = 1'b1; req_reg_a = 3'd5; req_reg_b = 3'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("abort_x.en_write", bank_en_write, 1'b0);
    check_output("abort_x.rsp_valid", rsp_valid, 1'b0);
    m_write(1'b1, 3'd5, vb);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_bank("abort_x.bank");
    check_output("abort_x.b_kept", bank_regs[6], vb);
    check_output("abort_x.a_written", bank_regs[5], vb);
`else
    va = 16'h0; vb = 16'h0;
    check_output("final.rsp_valid", rsp_valid, 1'b0);
`endif
    check_output("final.err", err, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
